// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch control core.
// Holds the state enum, mode codes, BCD limits and preset helpers.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } sw_state_e;

    localparam logic [1:0] MODE_UP0    = 2'd0;
    localparam logic [1:0] MODE_UP_PRE = 2'd1;
    localparam logic [1:0] MODE_DN99   = 2'd2;
    localparam logic [1:0] MODE_DN_PRE = 2'd3;

    localparam logic [15:0] BCD_MAX  = 16'h9999;
    localparam logic [15:0] BCD_ZERO = 16'h0000;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > 4'd9) ? 4'd9 : nibble;
    endfunction

    // Preset seconds come from sw; the hundredths part always starts at .00
    function automatic logic [15:0] preset_value(input logic [1:0] mode,
                                                 input logic [7:0] sw);
        logic [15:0] value;
        case (mode)
            MODE_UP0:  value = BCD_ZERO;
            MODE_DN99: value = BCD_MAX;
            default:   value = {bcd_clamp(sw[7:4]), bcd_clamp(sw[3:0]), 8'h00};
        endcase
        return value;
    endfunction

    function automatic logic mode_counts_up(input logic [1:0] mode);
        return (mode == MODE_UP0) || (mode == MODE_UP_PRE);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// User-side signal bundle of the stopwatch core: button, mode, preset and
// the BCD time / status outputs feeding the display block.
interface stopwatch_ctrl_if;

    logic        startstop;
    logic [1:0]  mode;
    logic [7:0]  sw;
    logic [15:0] digits;
    logic        running;
    logic        done;

    modport master (
        output startstop, mode, sw,
        input  digits, running, done
    );

    modport slave (
        input  startstop, mode, sw,
        output digits, running, done
    );

endinterface

// File: rtl/stopwatch_ctrl_bcd_counter.sv
// 4-digit BCD up/down counter with synchronous load and step enable.
// Reports whether the held value, or the value one step away, is terminal.
module bcd_updown_counter4
    import stopwatch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    input  logic        up,
    output logic [15:0] digits,
    output logic        at_term,
    output logic        next_term
);

    logic [15:0] stepped;
    logic [15:0] terminal;

    // Ripple carry/borrow nibble by nibble; wrap is never committed because
    // the controller stops stepping once the terminal value is reached.
    function automatic logic [15:0] bcd_step(input logic [15:0] value, input logic dir_up);
        logic [15:0] res;
        logic        carry;
        logic [3:0]  nib;
        res   = value;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nib = value[4*i +: 4];
            if (carry) begin
                if (dir_up) begin
                    if (nib == 4'd9) begin
                        res[4*i +: 4] = 4'd0;
                    end else begin
                        res[4*i +: 4] = nib + 4'd1;
                        carry         = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0) begin
                        res[4*i +: 4] = 4'd9;
                    end else begin
                        res[4*i +: 4] = nib - 4'd1;
                        carry         = 1'b0;
                    end
                end
            end
        end
        return res;
    endfunction

    assign stepped   = bcd_step(digits, up);
    assign terminal  = up ? BCD_MAX : BCD_ZERO;
    assign at_term   = (digits == terminal);
    assign next_term = (stepped == terminal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits <= BCD_ZERO;
        end else if (load) begin
            digits <= load_val;
        end else if (en) begin
            digits <= stepped;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control core: startstop conditioning, 0.01 s prescaler,
// IDLE/RUN/PAUSE/DONE state machine and the BCD time counter.
// Optional input debouncer enabled by defining STOPWATCH_DEBOUNCE_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = 1000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_ctrl_if.slave  bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("stopwatch_ctrl: TICK_DIV must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    sw_state_e   state;
    sw_state_e   state_nxt;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic        dir;
    logic        dir_nxt;
    logic        running_q;
    logic        done_q;

    logic        sync_p0;
    logic        sync_p1;
    logic        ss_lvl;
    logic        lvl_p2;
    logic        ss_evt;

    logic        tick;
    logic        cnt_load;
    logic        cnt_en;
    logic [15:0] digits_q;
    logic        at_term;
    logic        next_term;

    // Stage 0/1: two-flop synchronizer on the raw button level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= bus.startstop;
            sync_p1 <= sync_p0;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] db_cnt;
    logic          db_lvl;

    // Accept a new level only after it has been stable for DEBOUNCE_CYCLES
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt <= '0;
            db_lvl <= 1'b0;
        end else if (sync_p1 == db_lvl) begin
            db_cnt <= '0;
        end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt <= '0;
            db_lvl <= sync_p1;
        end else begin
            db_cnt <= db_cnt + DW'(1);
        end
    end

    assign ss_lvl = db_lvl;
`else
    assign ss_lvl = sync_p1;
`endif

    // Stage 2: registered rising-edge detect -> one-cycle ss_evt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_p2 <= 1'b0;
            ss_evt <= 1'b0;
        end else begin
            lvl_p2 <= ss_lvl;
            ss_evt <= ss_lvl & ~lvl_p2;
        end
    end

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        dir_nxt   = dir;
        tick      = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE: begin
                cnt_load  = 1'b1;
                presc_nxt = '0;
                if (ss_evt) begin
                    state_nxt = RUN;
                    dir_nxt   = mode_counts_up(bus.mode);
                end
            end
            RUN: begin
                tick      = (presc == PRESC_TOP);
                presc_nxt = tick ? '0 : presc + PW'(1);
                // A tick's outcome outranks a coincident startstop event
                if (tick) begin
                    if (at_term) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_en = 1'b1;
                        if (next_term) begin
                            state_nxt = DONE;
                        end else if (ss_evt) begin
                            state_nxt = PAUSE;
                        end
                    end
                end else if (ss_evt) begin
                    state_nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (ss_evt) begin
                    state_nxt = RUN;
                end
            end
            DONE: begin
                if (ss_evt) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they align with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            presc     <= '0;
            dir       <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            dir       <= dir_nxt;
            running_q <= (state_nxt == RUN);
            done_q    <= (state_nxt == DONE);
        end
    end

    bcd_updown_counter4 u_counter (
        .clk       (clk),
        .rst       (reset),
        .load      (cnt_load),
        .load_val  (preset_value(bus.mode, bus.sw)),
        .en        (cnt_en),
        .up        (dir),
        .digits    (digits_q),
        .at_term   (at_term),
        .next_term (next_term)
    );

    assign bus.digits  = digits_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4: directed stimulus, literal
// expectations and an integer-level stopwatch model compared every cycle.
module tb_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    stopwatch_ctrl_if bus();

    stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: time as a plain integer 0..9999, hist = last four button samples
    typedef struct {
        int       st;
        int       val;
        int       ph;
        bit       up;
        bit [3:0] hist;
    } model_t;

    model_t m = '{st: M_IDLE, val: 0, ph: 0, up: 1'b1, hist: 4'b0};

    function automatic int preset(input logic [1:0] md, input logic [7:0] s);
        int hi;
        int lo;
        hi = (s[7:4] > 4'd9) ? 9 : int'(s[7:4]);
        lo = (s[3:0] > 4'd9) ? 9 : int'(s[3:0]);
        case (md)
            2'd0:    return 0;
            2'd2:    return 9999;
            default: return hi * 1000 + lo * 100;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic model_t step(input model_t c, input logic ss,
                                    input logic [1:0] md, input logic [7:0] s);
        model_t n;
        bit     evt;
        int     term;
        n      = c;
        evt    = c.hist[2] & ~c.hist[3];
        n.hist = {c.hist[2:0], ss};
        term   = c.up ? 9999 : 0;
        case (c.st)
            M_IDLE: begin
                n.val = preset(md, s);
                if (evt) begin
                    n.st = M_RUN;
                    n.ph = 0;
                    n.up = (md == 2'd0) || (md == 2'd1);
                end
            end
            M_RUN: begin
                if (c.ph == TD - 1) begin
                    n.ph = 0;
                    if (c.val == term) begin
                        n.st = M_DONE;
                    end else begin
                        n.val = c.up ? c.val + 1 : c.val - 1;
                        if (n.val == term) n.st = M_DONE;
                        else if (evt)      n.st = M_PAUSE;
                    end
                end else begin
                    n.ph = c.ph + 1;
                    if (evt) n.st = M_PAUSE;
                end
            end
            M_PAUSE: if (evt) n.st = M_RUN;
            default: if (evt) n.st = M_IDLE;
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '{st: M_IDLE, val: 0, ph: 0, up: 1'b1, hist: 4'b0};
        else       m <= step(m, bus.startstop, bus.mode, bus.sw);
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            n_cmp++;
            if (bus.digits !== to_bcd(m.val) || bus.running !== (m.st == M_RUN) ||
                bus.done !== (m.st == M_DONE)) begin
                n_bad++;
                $display("FAIL model t=%0t digits=%h want %h running=%b want %b done=%b want %b",
                         $time, bus.digits, to_bcd(m.val), bus.running, (m.st == M_RUN),
                         bus.done, (m.st == M_DONE));
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // which: 0 = running, 1 = done; bounded wait on the negedge
    task automatic wait_sig(input string name, input int which, input logic val, input int budget);
        int n = 0;
        while (((which == 0) ? bus.running : bus.done) !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (((which == 0) ? bus.running : bus.done) !== val) begin
            n_bad++;
            $display("FAIL %s: got no level %b within %0d cycles", name, val, budget);
        end
    endtask

    task automatic pulse();
        bus.startstop = 1'b1;
        repeat (2) @(negedge clk);
        bus.startstop = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        reset = 1'b1;
        bus.startstop = 1'b0;
        bus.mode = 2'd0;
        bus.sw = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_digits", bus.digits, 16'h0000);
        check_bit("rst_running", bus.running, 1'b0);
        check_bit("rst_done", bus.done, 1'b0);
        reset = 1'b0;

        // Mode 0: up from 00.00
        repeat (2) @(negedge clk);
        pulse();
        wait_sig("up0_start", 0, 1'b1, 10);
        check("up0_r0", bus.digits, 16'h0000);
        repeat (4) @(negedge clk);
        check("up0_step1", bus.digits, 16'h0001);
        repeat (36) @(negedge clk);
        check("up0_step10", bus.digits, 16'h0010);
        check_bit("up0_running", bus.running, 1'b1);

        // Mode 1 from 88: run through to the 99.99 terminal
        bus.mode = 2'd1;
        bus.sw = 8'h88;
        do_reset();
        repeat (2) @(negedge clk);
        check("up_pre_idle", bus.digits, 16'h8800);
        pulse();
        wait_sig("up_pre_start", 0, 1'b1, 10);
        repeat (4) @(negedge clk);
        check("up_pre_step1", bus.digits, 16'h8801);
        wait_sig("up_pre_done", 1, 1'b1, 6000);
        check("up_done_digits", bus.digits, 16'h9999);
        check_bit("up_done_running", bus.running, 1'b0);
        repeat (25) @(negedge clk);
        check("up_done_hold", bus.digits, 16'h9999);
        check_bit("up_done_hold_flag", bus.done, 1'b1);
        pulse();
        wait_sig("done_to_idle", 1, 1'b0, 10);
        @(negedge clk);
        check("done_reload", bus.digits, 16'h8800);

        // Mode 2 from 99.99, then a mode change mid-run must not flip direction
        bus.mode = 2'd2;
        repeat (2) @(negedge clk);
        check("dn99_idle", bus.digits, 16'h9999);
        pulse();
        wait_sig("dn99_start", 0, 1'b1, 10);
        repeat (4) @(negedge clk);
        check("dn99_step1", bus.digits, 16'h9998);
        bus.mode = 2'd0;
        repeat (4) @(negedge clk);
        check("dir_latched", bus.digits, 16'h9997);
        #2 reset = 1'b1;
        #1;
        check("async_rst_digits", bus.digits, 16'h0000);
        check_bit("async_rst_running", bus.running, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Mode 3 with sw=00: terminal on the very first tick, no step
        bus.mode = 2'd3;
        bus.sw = 8'h00;
        repeat (2) @(negedge clk);
        check("dn_pre0_idle", bus.digits, 16'h0000);
        pulse();
        wait_sig("dn_pre0_start", 0, 1'b1, 10);
        repeat (3) @(negedge clk);
        check_bit("zero_run_r3", bus.running, 1'b1);
        @(negedge clk);
        check_bit("zero_run_done", bus.done, 1'b1);
        check_bit("zero_run_stopped", bus.running, 1'b0);
        check("zero_run_digits", bus.digits, 16'h0000);
        pulse();
        wait_sig("zero_run_idle", 1, 1'b0, 10);

        // Out-of-range preset nibbles clamp to 9
        bus.mode = 2'd1;
        bus.sw = 8'hFA;
        repeat (2) @(negedge clk);
        check("clamp_fa", bus.digits, 16'h9900);

        // Pause keeps the partial prescaler phase
        bus.mode = 2'd0;
        do_reset();
        repeat (2) @(negedge clk);
        pulse();
        wait_sig("pause_start", 0, 1'b1, 10);
        repeat (2) @(negedge clk);
        pulse();
        wait_sig("pause_enter", 0, 1'b0, 10);
        check("pause_digits", bus.digits, 16'h0001);
        repeat (50) @(negedge clk);
        check("pause_hold", bus.digits, 16'h0001);
        check_bit("pause_not_running", bus.running, 1'b0);
        pulse();
        wait_sig("resume", 0, 1'b1, 10);
        @(negedge clk);
        check("resume_q1", bus.digits, 16'h0001);
        @(negedge clk);
        check("resume_q2", bus.digits, 16'h0002);

        // startstop coincident with the tick that reaches 00.00 -> DONE
        bus.mode = 2'd3;
        bus.sw = 8'h01;
        do_reset();
        repeat (2) @(negedge clk);
        check("coin_idle", bus.digits, 16'h0100);
        pulse();
        wait_sig("coin_start", 0, 1'b1, 10);
        repeat (396) @(negedge clk);
        pulse();
        wait_sig("coin_done", 1, 1'b1, 10);
        check("coin_digits", bus.digits, 16'h0000);
        check_bit("coin_not_running", bus.running, 1'b0);
        repeat (5) @(negedge clk);
        check_bit("coin_done_hold", bus.done, 1'b1);
        pulse();
        wait_sig("coin_to_idle", 1, 1'b0, 10);
        @(negedge clk);
        check("coin_reload", bus.digits, 16'h0100);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control and counting core for the 4-digit stopwatch display path.
- Turns the startstop pulse, mode[1:0] and the sw preset into a 4-digit BCD time value SS.hh.
- Owns the 0.01 s prescaler, the run/pause/done state machine and the up/down BCD counter.
- Its digits output feeds the existing seven-segment time-multiplexing display block.

Parameters:
TICK_DIV, 1000000, clk cycles per 0.01 s count step (100 MHz clock); legal range >= 2.
DEBOUNCE_CYCLES, 500000, stable cycles required on startstop before acceptance; used only with DEBOUNCE_EN.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset; also serves as the user reset button.
startstop  in  1  asynchronous button level; rising edge toggles run/pause.
mode  in  2  0 up from 00.00; 1 up from preset; 2 down from 99.99; 3 down from preset.
sw  in  8  preset seconds: sw[7:4] tens digit, sw[3:0] units digit (BCD).
digits  out  16  BCD time: [15:12] tens s, [11:8] s, [7:4] tenths, [3:0] hundredths.
running  out  1  high while in RUN.
done  out  1  high while in DONE (terminal value reached).

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: state=IDLE, digits=16'h0000, running=0, done=0, prescaler=0, sync/edge flops=0.
- startstop input path: 2-flop synchronizer, then rising-edge detect producing a 1-cycle pulse `ss_evt`.
  - Input rising before edge N gives ss_evt high during cycle N+2.
  - The state changes at edge N+3.
- Preset value:
  - Modes 0 and 1 count up; modes 2 and 3 count down.
  - mode0 = 0000; mode1 = {sw[7:4], sw[3:0], 0, 0}; mode2 = 9999; mode3 = {sw[7:4], sw[3:0], 0, 0}.
  - Any sw nibble > 9 is clamped to 9.
- IDLE:
  - digits reloads from the preset every cycle, so mode and sw changes track live.
  - ss_evt -> RUN, with the prescaler cleared.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps; tick = (prescaler == TICK_DIV-1).
  - On tick, digits steps ±1 with BCD carry/borrow across all 4 digits (e.g. 09.99 -> 10.00; 10.00 -> 09.99).
  - ss_evt -> PAUSE.
- PAUSE:
  - Prescaler and digits hold, so the elapsed fraction of the step is kept.
  - ss_evt -> RUN, and counting resumes from the held prescaler value.
- Terminal:
  - Up count: a step producing 99.99 -> DONE.
  - Down count: a step producing 00.00 -> DONE.
  - digits holds the terminal value.
  - The value is never wrapped past 99.99 or below 00.00.
- Zero-length run: starting in RUN with digits already at the terminal (mode 3 with sw=00, or mode 1 with sw=99 after the trailing 00 … not terminal) goes to DONE on the first tick without stepping.
  - Only exact 99.99 (up) or 00.00 (down) counts as terminal.
- DONE:
  - ss_evt -> IDLE, which reloads the preset next cycle.
  - Otherwise held.
- mode is sampled only in IDLE. A mode change during RUN, PAUSE or DONE is ignored until the return to IDLE. The count direction is latched on IDLE->RUN.
- Simultaneous tick and ss_evt in RUN:
  - The step is applied.
  - If the step reaches the terminal, the next state is DONE; otherwise PAUSE.
- Reset asserted mid-run: immediately forces the reset values. After release, IDLE loads the preset on the first clock edge.
- running = (state==RUN); done = (state==DONE). Both are registered state decodes with no extra latency.

Optional Feature:
STOPWATCH_DEBOUNCE_EN:
- Defined: a debouncer sits between the synchronizer and the edge detect. The filtered level changes only after the synchronized input has held a new value for DEBOUNCE_CYCLES consecutive cycles. ss_evt lags the input by DEBOUNCE_CYCLES+3 edges. Glitches shorter than that are ignored.
- Undefined: synchronizer plus edge detect only, as described above.

Decomposition:
- stopwatch_pkg:
  - state enum IDLE/RUN/PAUSE/DONE.
  - mode constants MODE_UP0, MODE_UP_PRE, MODE_DN99, MODE_DN_PRE.
  - BCD_MAX=16'h9999, BCD_ZERO=16'h0000.
  - Function bcd_clamp(nibble).
- Sub-module bcd_updown_counter4:
  - 4-digit BCD counter with load, enable and direction.
  - Outputs: digits and a terminal flag for the next-state value.
  - The FSM, prescaler and input conditioning stay in stopwatch_ctrl.

Test Plan (TICK_DIV=4, feature off):
- mode=0, reset pulse, startstop pulse -> digits 0000 -> 0001 after 4 RUN cycles; 0010 after 40 cycles; running=1.
- mode=1, sw=8'h88 -> IDLE digits=8800; after start, 8801 after 4 cycles; count continues to 9999, then done=1, running=0 and digits holds 9999 for 20+ cycles.
- mode=2 -> digits=9999; after start, 9998 after 4 cycles. mode=3, sw=8'h00: after start, DONE on the first tick with digits=0000.
- Pause/resume: start in mode 0, pulse startstop after 6 cycles -> digits=0001 held for 50 cycles; second pulse -> 0002 exactly 2 cycles after resume.
- sw=8'hFA in mode 1 -> digits=9900 (clamped). Change mode to 2 during RUN -> direction unchanged. Assert reset mid-run -> digits=0000, running=0 immediately without a clock edge.
- ss_evt coincident with the tick producing 0000 in mode 2/3 -> state DONE (not PAUSE); the next startstop pulse -> IDLE with the preset reloaded.
